// File: rtl/dmem_access_unit_if.sv
// Pipeline-side access controls, data-memory bus and status returned to the pipeline.
// slave is the access unit's view; master is the pipeline/memory environment.
interface dmem_access_unit_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              acc_valid_i;
  logic              acc_we_i;
  logic [ADDR_W-1:0] acc_addr_i;
  logic [31:0]       acc_wdata_i;
  logic [3:0]        acc_wbe_i;
  logic [1:0]        acc_rsize_i;
  logic              acc_unsigned_i;

  logic              mem_req_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [3:0]        mem_be_o;
  logic [31:0]       mem_wdata_o;
  logic              mem_gnt_i;
  logic              mem_rvalid_i;
  logic [31:0]       mem_rdata_i;

  logic              stall_o;
  logic              done_o;
  logic [31:0]       rdata_o;
  logic              misalign_err_o;
  logic              bus_err_o;

  modport slave (
    input  acc_valid_i, acc_we_i, acc_addr_i, acc_wdata_i, acc_wbe_i, acc_rsize_i,
           acc_unsigned_i, mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    output mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
           stall_o, done_o, rdata_o, misalign_err_o, bus_err_o
  );

  modport master (
    output acc_valid_i, acc_we_i, acc_addr_i, acc_wdata_i, acc_wbe_i, acc_rsize_i,
           acc_unsigned_i, mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
           stall_o, done_o, rdata_o, misalign_err_o, bus_err_o
  );
endinterface

// File: rtl/dmem_access_unit.sv
// Data-memory access stage: lane alignment, req/gnt/rvalid sequencing, load extension
// and bus timeout, stalling the pipeline while an access is in flight.
module dmem_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned ADDR_W         = 32
) (
  input logic               clk,
  input logic               rst_n,
  dmem_access_unit_if.slave bus
);
  localparam int unsigned      CNT_W    = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT_R = 2'd2,
    DONE   = 2'd3
  } state_e;

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              req_q;
  logic              we_q;
  logic              uns_q;
  logic              err_q;
  logic [1:0]        rsize_q;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        be_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;

  logic [1:0]  off_c;
  logic        is_word_c;
  logic        is_half_c;
  logic        misaligned_c;
  logic        accept_c;
  logic        misalign_c;
  logic        expire_c;
  logic [3:0]  size_mask_c;
  logic [3:0]  be_c;
  logic [31:0] rd_shift_c;
  logic [31:0] rd_ext_c;

  // Access size decode and alignment check on the incoming request
  always_comb begin
    off_c       = bus.acc_addr_i[1:0];
    is_word_c   = 1'b0;
    is_half_c   = 1'b0;
    size_mask_c = bus.acc_wbe_i;
    if (bus.acc_we_i) begin
      is_word_c = (bus.acc_wbe_i == 4'b1111);
      is_half_c = (bus.acc_wbe_i == 4'b0011);
    end else begin
      is_word_c = bus.acc_rsize_i[1];
      is_half_c = (bus.acc_rsize_i == 2'b01);
      unique case (bus.acc_rsize_i)
        2'b00:   size_mask_c = 4'b0001;
        2'b01:   size_mask_c = 4'b0011;
        default: size_mask_c = 4'b1111;
      endcase
    end
    misaligned_c = (is_half_c & off_c[0]) | (is_word_c & (off_c != 2'b00));
    accept_c     = (state_q == IDLE) & bus.acc_valid_i & ~misaligned_c;
    misalign_c   = (state_q == IDLE) & bus.acc_valid_i & misaligned_c;
    expire_c     = (cnt_q >= CNT_LAST);
    be_c         = size_mask_c << off_c;
  end

  // Pick the addressed byte/half out of the returned word and extend it
  always_comb begin
    rd_shift_c = bus.mem_rdata_i >> {addr_q[1:0], 3'b000};
    unique case (rsize_q)
      2'b00:   rd_ext_c = uns_q ? {24'h0, rd_shift_c[7:0]}
                                : {{24{rd_shift_c[7]}}, rd_shift_c[7:0]};
      2'b01:   rd_ext_c = uns_q ? {16'h0, rd_shift_c[15:0]}
                                : {{16{rd_shift_c[15]}}, rd_shift_c[15:0]};
      default: rd_ext_c = bus.mem_rdata_i;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      rsize_q <= 2'b00;
      addr_q  <= '0;
      be_q    <= 4'b0000;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
    end else begin
      err_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (accept_c) begin
            addr_q  <= bus.acc_addr_i;
            we_q    <= bus.acc_we_i;
            uns_q   <= bus.acc_unsigned_i;
            rsize_q <= bus.acc_rsize_i;
            be_q    <= be_c;
            wdata_q <= bus.acc_wdata_i << {off_c, 3'b000};
            cnt_q   <= '0;
            req_q   <= 1'b1;
            state_q <= REQ;
          end
        end
        REQ: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (bus.mem_gnt_i) begin
            req_q   <= 1'b0;
            state_q <= we_q ? DONE : WAIT_R;
          end else if (expire_c) begin
            req_q   <= 1'b0;
            err_q   <= 1'b1;
            rdata_q <= 32'h0;
            state_q <= DONE;
          end
        end
        WAIT_R: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (bus.mem_rvalid_i) begin
            rdata_q <= rd_ext_c;
            state_q <= DONE;
          end else if (expire_c) begin
            err_q   <= 1'b1;
            rdata_q <= 32'h0;
            state_q <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          req_q   <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.mem_req_o      = req_q;
  assign bus.mem_we_o       = we_q;
  assign bus.mem_addr_o     = {addr_q[ADDR_W-1:2], 2'b00};
  assign bus.mem_be_o       = be_q;
  assign bus.mem_wdata_o    = wdata_q;
  // Misaligned accesses complete in the same IDLE cycle without touching the bus
  assign bus.stall_o        = accept_c | (state_q == REQ) | (state_q == WAIT_R);
  assign bus.done_o         = (state_q == DONE) | misalign_c;
  assign bus.rdata_o        = rdata_q;
  assign bus.misalign_err_o = misalign_c;
  assign bus.bus_err_o      = err_q;
endmodule

// File: tb/tb_dmem_access_unit.sv
// Self-checking bench for dmem_access_unit: a transaction-level timing/data model
// sets per-cycle expectations; a negedge process compares every DUT output.
module tb_dmem_access_unit;
  localparam int unsigned TO = 8;
  localparam int unsigned AW = 32;

  logic clk;
  logic rst_n;

  dmem_access_unit_if #(.ADDR_W(AW)) bus ();

  dmem_access_unit #(.TIMEOUT_CYCLES(TO), .ADDR_W(AW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic        chk_en;
  logic        e_stall, e_done, e_req, e_merr, e_berr, e_we, e_rst;
  logic [31:0] e_rdata, e_addr, e_wdata;
  logic [3:0]  e_be;
  logic [31:0] last_rd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=0x%08h required=0x%08h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("stall", 32'(bus.stall_o), 32'(e_stall));
      chk("done", 32'(bus.done_o), 32'(e_done));
      chk("req", 32'(bus.mem_req_o), 32'(e_req));
      chk("misalign_err", 32'(bus.misalign_err_o), 32'(e_merr));
      chk("bus_err", 32'(bus.bus_err_o), 32'(e_berr));
      chk("rdata", bus.rdata_o, e_rdata);
      if (e_req) begin
        chk("mem_we", 32'(bus.mem_we_o), 32'(e_we));
        chk("mem_addr", bus.mem_addr_o, e_addr);
        if (e_we) begin
          chk("mem_be", 32'(bus.mem_be_o), 32'(e_be));
          chk("mem_wdata", bus.mem_wdata_o, e_wdata);
        end
      end
      if (e_rst) begin
        chk("rst_we", 32'(bus.mem_we_o), 32'h0);
        chk("rst_addr", bus.mem_addr_o, 32'h0);
        chk("rst_be", 32'(bus.mem_be_o), 32'h0);
        chk("rst_wdata", bus.mem_wdata_o, 32'h0);
      end
    end
  end

  function automatic int size_bytes(input logic we, input logic [3:0] wbe, input logic [1:0] rsize);
    if (we) return (wbe == 4'b1111) ? 4 : ((wbe == 4'b0011) ? 2 : 1);
    return (rsize == 2'b00) ? 1 : ((rsize == 2'b01) ? 2 : 4);
  endfunction

  // Arithmetic view of load extraction: divide down to the offset, keep n bytes, sign-adjust
  function automatic logic [31:0] ext_model(input logic [31:0] w, input int off, input int n,
                                            input logic uns);
    longint v;
    longint span;
    span = longint'(1) << (8 * n);
    v = (longint'(w) / (longint'(1) << (8 * off))) % span;
    if (!uns && v >= span / 2) v = v - span;
    return 32'(v);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_exp(input logic stall, input logic done, input logic req,
                         input logic merr, input logic berr, input logic [31:0] rd);
    e_stall = stall; e_done = done; e_req = req; e_merr = merr; e_berr = berr; e_rdata = rd;
  endtask

  task automatic scramble();
    bus.acc_we_i       = 1'($urandom);
    bus.acc_addr_i     = $urandom;
    bus.acc_wdata_i    = $urandom;
    bus.acc_wbe_i      = 4'($urandom);
    bus.acc_rsize_i    = 2'($urandom);
    bus.acc_unsigned_i = 1'($urandom);
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) begin
      scramble();
      bus.acc_valid_i  = 1'b0;
      bus.mem_gnt_i    = 1'b0;
      bus.mem_rvalid_i = 1'($urandom);
      bus.mem_rdata_i  = $urandom;
      set_exp(0, 0, 0, 0, 0, last_rd);
      tick();
    end
  endtask

  // gd: REQ cycles before grant; rd: WAIT_R cycles before rvalid (>= TO means never)
  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wbe, input logic [1:0] rsize, input logic uns,
                        input int gd, input int rd, input logic [31:0] rword,
                        input bit pin_en, input logic [31:0] pin_v, input logic [3:0] pin_be);
    int n, off, req_n, p, nb;
    bit mis, err, in_req;
    n   = size_bytes(we, wbe, rsize);
    off = int'(addr[1:0]);
    mis = (off % n) != 0;
    bus.acc_valid_i    = 1'b1;
    bus.acc_we_i       = we;
    bus.acc_addr_i     = addr;
    bus.acc_wdata_i    = wdata;
    bus.acc_wbe_i      = wbe;
    bus.acc_rsize_i    = rsize;
    bus.acc_unsigned_i = uns;
    bus.mem_gnt_i      = 1'b0;
    bus.mem_rvalid_i   = 1'($urandom);
    bus.mem_rdata_i    = $urandom;
    set_exp(!mis, mis, 0, mis, 0, last_rd);
    tick();
    if (mis) return;
    e_we    = we;
    e_addr  = addr - 32'(off);
    e_be    = 4'(int'(wbe) * (1 << off));
    e_wdata = 32'(longint'(wdata) * (longint'(1) << (8 * off)));
    req_n = gd + 1;
    p     = gd + 2 + rd;
    err   = (req_n > int'(TO)) || (!we && p > int'(TO));
    nb    = err ? int'(TO) : (we ? req_n : p);
    for (int k = 1; k <= nb; k++) begin
      in_req = (k <= req_n);
      scramble();
      bus.acc_valid_i = 1'b1;
      bus.mem_gnt_i   = (k == req_n);
      if (in_req) begin
        bus.mem_rvalid_i = 1'($urandom);
        bus.mem_rdata_i  = $urandom;
      end else begin
        bus.mem_rvalid_i = (k == p);
        bus.mem_rdata_i  = (k == p) ? rword : $urandom;
      end
      set_exp(1, 0, in_req, 0, 0, last_rd);
      if (pin_en && we && k == 1) begin
        #3;
        chk("pin_be", 32'(bus.mem_be_o), 32'(pin_be));
        chk("pin_wdata", bus.mem_wdata_o, pin_v);
      end
      tick();
    end
    scramble();
    bus.acc_valid_i  = 1'b1;
    bus.mem_gnt_i    = 1'b0;
    bus.mem_rvalid_i = 1'($urandom);
    bus.mem_rdata_i  = $urandom;
    set_exp(0, 1, 0, 0, err, err ? 32'h0 : (we ? last_rd : ext_model(rword, off, n, uns)));
    last_rd = e_rdata;
    if (pin_en && !we) begin
      #3;
      chk("pin_rdata", bus.rdata_o, pin_v);
    end
    tick();
  endtask

  // Word load abandoned by an async reset at busy cycle kr (grant after gd REQ cycles)
  task automatic rst_mid(input int kr, input int gd);
    logic [31:0] a;
    a = $urandom;
    a[1:0] = 2'b00;
    bus.acc_valid_i = 1'b1; bus.acc_we_i = 1'b0; bus.acc_addr_i = a;
    bus.acc_rsize_i = 2'b10; bus.acc_unsigned_i = 1'b0;
    bus.mem_gnt_i = 1'b0; bus.mem_rvalid_i = 1'b0;
    e_we = 1'b0; e_addr = a;
    set_exp(1, 0, 0, 0, 0, last_rd);
    tick();
    for (int k = 1; k < kr; k++) begin
      bus.mem_gnt_i    = (k == gd + 1);
      bus.mem_rvalid_i = (k <= gd + 1) ? 1'($urandom) : 1'b0;
      set_exp(1, 0, (k <= gd + 1), 0, 0, last_rd);
      tick();
    end
    bus.mem_gnt_i = 1'b0; bus.mem_rvalid_i = 1'b0;
    last_rd = 32'h0;
    set_exp(0, 0, 0, 0, 0, 32'h0);
    e_rst = 1'b1;
    #1;
    rst_n = 1'b0;
    bus.acc_valid_i = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    e_rst = 1'b0;
  endtask

  initial begin
    logic        r_we;
    logic [3:0]  r_wbe;
    int          r_gd, r_rd, pick;
    chk_en = 1'b0;
    rst_n  = 1'b0;
    bus.acc_valid_i = 1'b0; bus.acc_we_i = 1'b0; bus.acc_addr_i = '0; bus.acc_wdata_i = '0;
    bus.acc_wbe_i = '0; bus.acc_rsize_i = '0; bus.acc_unsigned_i = 1'b0;
    bus.mem_gnt_i = 1'b0; bus.mem_rvalid_i = 1'b0; bus.mem_rdata_i = '0;
    e_we = 0; e_addr = 0; e_be = 0; e_wdata = 0; e_rst = 1'b1;
    last_rd = 32'h0;
    set_exp(0, 0, 0, 0, 0, 32'h0);
    chk_en = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    e_rst = 1'b0;
    gap(2);

    access(1, 32'h100, 32'hDEADBEEF, 4'hF, 2'b10, 0, 0, 0, 32'h0, 1, 32'hDEADBEEF, 4'hF);
    access(1, 32'h103, 32'h000000AB, 4'h1, 2'b00, 0, 0, 0, 32'h0, 1, 32'hAB000000, 4'h8);
    gap(1);
    access(0, 32'h202, 32'h0, 4'h0, 2'b01, 0, 0, 0, 32'h80011234, 1, 32'hFFFF8001, 4'h0);
    access(0, 32'h202, 32'h0, 4'h0, 2'b01, 1, 1, 1, 32'h80011234, 1, 32'h00008001, 4'h0);
    access(0, 32'h201, 32'h0, 4'h0, 2'b00, 1, 0, 0, 32'h80011234, 1, 32'h00000012, 4'h0);
    access(0, 32'h006, 32'h0, 4'h0, 2'b10, 0, 0, 0, 32'h0, 0, 32'h0, 4'h0);
    gap(1);
    access(1, 32'h101, 32'h1234, 4'h3, 2'b00, 0, 0, 0, 32'h0, 0, 32'h0, 4'h0);
    gap(1);
    access(0, 32'h300, 32'h0, 4'h0, 2'b10, 0, 4, 2, 32'hCAFEF00D, 1, 32'hCAFEF00D, 4'h0);
    access(1, 32'h400, 32'h55AA55AA, 4'hF, 2'b10, 0, 100, 0, 32'h0, 0, 32'h0, 4'h0);
    gap(1);
    access(0, 32'h404, 32'h0, 4'h0, 2'b10, 0, 100, 0, 32'h0, 1, 32'h0, 4'h0);
    access(1, 32'h408, 32'h01020304, 4'hF, 2'b10, 0, 7, 0, 32'h0, 1, 32'h01020304, 4'hF);
    access(0, 32'h40C, 32'h0, 4'h0, 2'b10, 0, 0, 6, 32'h87654321, 1, 32'h87654321, 4'h0);
    access(0, 32'h410, 32'h0, 4'h0, 2'b10, 0, 0, 7, 32'h87654321, 1, 32'h0, 4'h0);
    rst_mid(3, 5);
    gap(1);
    access(1, 32'h502, 32'h0000BEEF, 4'h3, 2'b00, 0, 1, 0, 32'h0, 1, 32'hBEEF0000, 4'hC);
    access(0, 32'h504, 32'h0, 4'h0, 2'b10, 0, 3, 0, 32'h1357ACE0, 1, 32'h1357ACE0, 4'h0);
    rst_mid(3, 0);
    gap(1);
    access(0, 32'h603, 32'h0, 4'h0, 2'b00, 0, 0, 1, 32'hF0A5C3E1, 1, 32'hFFFFFFF0, 4'h0);

    for (int i = 0; i < 300; i++) begin
      r_we = 1'($urandom);
      pick = int'($urandom_range(0, 2));
      r_wbe = (pick == 0) ? 4'h1 : ((pick == 1) ? 4'h3 : 4'hF);
      if ($urandom_range(0, 7) == 0) r_gd = 100;
      else r_gd = r_we ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 6));
      r_rd = ($urandom_range(0, 9) == 0) ? 100 : int'($urandom_range(0, 3));
      access(r_we, $urandom, $urandom, r_wbe, 2'($urandom), 1'($urandom), r_gd, r_rd,
             $urandom, 0, 32'h0, 4'h0);
      gap(int'($urandom_range(0, 2)));
    end

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
